// File: rtl/graded_counter_bank.sv
// graded_counter_bank: a bank of event counters whose widths grow by STEP_W per
// channel. Each channel counts, then wraps or saturates, and keeps a sticky
// overflow flag. A snapshot engine captures all channels in one cycle and
// streams the captured values out, one channel per valid/ready handshake.
//
// state  | meaning
// IDLE   | no stream in progress; snap_req captures all channels
// STREAM | presenting snapshot[beat]; advances on out_valid && out_ready
module graded_counter_bank #(
  parameter int CHANNELS = 3,
  parameter int BASE_W   = 1,
  parameter int STEP_W   = 2,
  parameter bit MODE_SAT = 1'b0,
  localparam int OUT_W   = BASE_W + STEP_W * (CHANNELS - 1),
  localparam int CH_W    = $clog2(CHANNELS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] inc_en,
  input  logic [CHANNELS-1:0] clr,
  input  logic                snap_req,
  output logic                snap_busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_ovf,
  output logic                out_last
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            beat_q, beat_d;
  logic [CHANNELS*OUT_W-1:0]  cnt_flat;
  logic [CHANNELS-1:0]        ovf_vec;
  logic [CHANNELS*OUT_W-1:0]  snap_data_q;
  logic [CHANNELS-1:0]        snap_ovf_q;
  logic                       capture;
  logic                       is_last;

  assign capture = (state_q == IDLE) && snap_req;
  assign is_last = (beat_q == CH_W'(CHANNELS - 1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int W = BASE_W + STEP_W * i;
    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    // Clear wins over increment; a capture clears the flag unless this same
    // cycle overflows again, so no overflow event is ever dropped.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr[i]) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        if (capture) ovf_d = 1'b0;
        if (inc_en[i]) begin
          if (cnt_q == {W{1'b1}}) begin
            cnt_d = MODE_SAT ? cnt_q : '0;
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
      end
    end

    // Live counter and sticky overflow registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_flat[i*OUT_W +: OUT_W] = OUT_W'(cnt_q);
    assign ovf_vec[i]                 = ovf_q;
  end

  // State, beat index and snapshot registers; snapshot takes pre-update values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      snap_data_q <= '0;
      snap_ovf_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (capture) begin
        snap_data_q <= cnt_flat;
        snap_ovf_q  <= ovf_vec;
      end
    end
  end

  // Next-state: snap_req only honoured in IDLE, stream ends after last beat.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d = STREAM;
          beat_d  = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CH_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs: driven from snapshot[beat] in STREAM, all zero otherwise.
  always_comb begin
    snap_busy = 1'b0;
    out_valid = 1'b0;
    out_ch    = '0;
    out_data  = '0;
    out_ovf   = 1'b0;
    out_last  = 1'b0;
    if (state_q == STREAM) begin
      snap_busy = 1'b1;
      out_valid = 1'b1;
      out_ch    = beat_q;
      out_last  = is_last;
      for (int i = 0; i < CHANNELS; i++) begin
        if (beat_q == CH_W'(i)) begin
          out_data = snap_data_q[i*OUT_W +: OUT_W];
          out_ovf  = snap_ovf_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_graded_counter_bank.sv
// Directed bench for graded_counter_bank: a wrapping and a saturating instance
// share all stimulus; expected values are hand-computed for widths 1,3,5.
module tb_graded_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] inc_en, clr;
  logic       snap_req, out_ready;

  logic       busy_w, valid_w, ovf_w, last_w;
  logic [2:0] ch_w;
  logic [4:0] data_w;
  logic       busy_s, valid_s, ovf_s, last_s;
  logic [2:0] ch_s;
  logic [4:0] data_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  graded_counter_bank #(.MODE_SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .inc_en(inc_en), .clr(clr), .snap_req(snap_req),
    .snap_busy(busy_w), .out_valid(valid_w), .out_ready(out_ready),
    .out_ch(ch_w), .out_data(data_w), .out_ovf(ovf_w), .out_last(last_w)
  );

  graded_counter_bank #(.MODE_SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .inc_en(inc_en), .clr(clr), .snap_req(snap_req),
    .snap_busy(busy_s), .out_valid(valid_s), .out_ready(out_ready),
    .out_ch(ch_s), .out_data(data_s), .out_ovf(ovf_s), .out_last(last_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  // Checks the beat currently presented, then completes its handshake.
  task automatic expect_beat(input int ch, input int d_wrap, input int d_sat,
                             input bit ovf, input bit last);
    int n = 0;
    while (!valid_w && n < 20) begin
      tick();
      n++;
    end
    check("beat_wait", 32'(valid_w), 32'd1);
    check("valid_sat", 32'(valid_s), 32'd1);
    check("busy", 32'(busy_w), 32'd1);
    check("ch", 32'(ch_w), 32'(ch));
    check("data_wrap", 32'(data_w), 32'(d_wrap));
    check("data_sat", 32'(data_s), 32'(d_sat));
    check("ovf_wrap", 32'(ovf_w), 32'(ovf));
    check("ovf_sat", 32'(ovf_s), 32'(ovf));
    check("last", 32'(last_w), 32'(last));
    out_ready = 1'b1;
    tick();
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(valid_w), 32'd0);
    check({tag, "_busy"}, 32'(busy_w), 32'd0);
    check({tag, "_valid_sat"}, 32'(valid_s), 32'd0);
  endtask

  initial begin
    rst = 1'b1; inc_en = '0; clr = '0; snap_req = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_data", 32'(data_w), 32'd0);
    check("rst_last", 32'(last_w), 32'd0);
    expect_idle("rst");
    rst = 1'b0;
    tick();

    // 1: seven increments of channel 2 only
    inc_en = 3'b100;
    repeat (7) tick();
    inc_en = '0;
    snap();
    expect_beat(0, 0, 0, 1'b0, 1'b0);
    expect_beat(1, 0, 0, 1'b0, 1'b0);
    expect_beat(2, 7, 7, 1'b0, 1'b1);
    expect_idle("t1_end");

    // 2: nine increments of ch1 (wrap vs saturate), three of ch0
    clr = 3'b111; tick(); clr = '0;
    inc_en = 3'b011;
    repeat (3) tick();
    inc_en = 3'b010;
    repeat (6) tick();
    inc_en = '0;
    snap();
    expect_beat(0, 1, 1, 1'b1, 1'b0);
    expect_beat(1, 1, 7, 1'b1, 1'b0);
    expect_beat(2, 0, 0, 1'b0, 1'b1);

    // 3: backpressure on beat 1 holds the outputs; overflow flags were cleared
    snap();
    expect_beat(0, 1, 1, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_valid", 32'(valid_w), 32'd1);
      check("hold_ch", 32'(ch_w), 32'd1);
      check("hold_data_wrap", 32'(data_w), 32'd1);
      check("hold_data_sat", 32'(data_s), 32'd7);
    end
    out_ready = 1'b1;
    expect_beat(1, 1, 7, 1'b0, 1'b0);
    expect_beat(2, 0, 0, 1'b0, 1'b1);

    // 4: clr beats inc_en; snap_req during the stream is ignored
    inc_en = 3'b100;
    repeat (3) tick();
    clr = 3'b100;
    tick();
    clr = '0; inc_en = '0;
    snap();
    snap_req = 1'b1;
    expect_beat(0, 1, 1, 1'b0, 1'b0);
    expect_beat(1, 1, 7, 1'b0, 1'b0);
    snap_req = 1'b0;
    expect_beat(2, 0, 0, 1'b0, 1'b1);
    expect_idle("t4_end");
    tick();
    expect_idle("t4_no_extra");

    // 5: increment in the capture cycle appears only in the next snapshot
    clr = 3'b111; tick(); clr = '0;
    snap_req = 1'b1; inc_en = 3'b001;
    tick();
    snap_req = 1'b0; inc_en = '0;
    expect_beat(0, 0, 0, 1'b0, 1'b0);
    expect_beat(1, 0, 0, 1'b0, 1'b0);
    expect_beat(2, 0, 0, 1'b0, 1'b1);
    snap();
    expect_beat(0, 1, 1, 1'b0, 1'b0);

    // 6: reset on beat 1 aborts the stream and clears the counters
    check("t6_on_beat1", 32'(ch_w), 32'd1);
    rst = 1'b1;
    tick();
    expect_idle("t6_rst");
    rst = 1'b0;
    tick();
    snap();
    expect_beat(0, 0, 0, 1'b0, 1'b0);
    expect_beat(1, 0, 0, 1'b0, 1'b0);
    expect_beat(2, 0, 0, 1'b0, 1'b1);
    expect_idle("t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
